// File: rtl/z_pulse_counter.sv
// rtl/z_pulse_counter.sv - counts synchronized z rising edges in 4-digit BCD and drives a multiplexed 7-segment display
// Optional feature: define Z_CNT_BLANK_EN to blank leading zero digits on the display.
module z_pulse_counter #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        z,
  input  logic        cnt_clr,
  output logic [15:0] count,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  logic          z_s1;
  logic          z_s2;
  logic          z_d;
  logic          inc;
  logic [15:0]   count_inc;
  logic          wrap;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    sel;
  logic [3:0]    digit;
  logic          blank;

  // Two-flop synchronizer for the slow-domain z, plus a history flop for edge detection
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      z_s1 <= 1'b0;
      z_s2 <= 1'b0;
      z_d  <= 1'b0;
    end else begin
      z_s1 <= z;
      z_s2 <= z_s1;
      z_d  <= z_s2;
    end
  end

  assign inc = z_s2 & ~z_d;

  // BCD +1 with ripple carry through the four digits; carry out of thousands marks a wrap
  always_comb begin
    logic carry;
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count[4*i +: 4] >= 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  // Count and sticky overflow; a clear on the same edge as an increment drops the increment
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= 16'h0000;
      ovf   <= 1'b0;
    end else if (cnt_clr) begin
      count <= 16'h0000;
      ovf   <= 1'b0;
    end else if (inc) begin
      count <= count_inc;
      if (wrap) begin
        ovf <= 1'b1;
      end
    end
  end

  // Refresh divider; each terminal count advances the digit select
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ref_cnt <= '0;
      sel     <= 2'd0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt <= '0;
      sel     <= sel + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Digit mux and leading-zero blanking decision for the current slot
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    case (sel)
      2'd0: digit = count[3:0];
      2'd1: digit = count[7:4];
      2'd2: digit = count[11:8];
      default: digit = count[15:12];
    endcase
`ifdef Z_CNT_BLANK_EN
    case (sel)
      2'd1: blank = (count[15:4] == 12'h000);
      2'd2: blank = (count[15:8] == 8'h00);
      2'd3: blank = (count[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
  end

  // Active-low anode and segment drive, {g,f,e,d,c,b,a}
  always_comb begin
    an  = 4'b1111;
    seg = 7'b1111111;
    if (!blank) begin
      an = ~(4'b0001 << sel);
      case (digit)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

endmodule

// File: tb/tb_z_pulse_counter.sv
// tb/tb_z_pulse_counter.sv - scoreboard bench for z_pulse_counter with REFRESH_DIV=4
module tb_z_pulse_counter;

  localparam int RD = 4;

  logic        clk;
  logic        clr_n;
  logic        z;
  logic        cnt_clr;
  logic [15:0] count;
  logic        ovf;
  logic [3:0]  an;
  logic [6:0]  seg;

  z_pulse_counter #(.REFRESH_DIV(RD)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .z       (z),
    .cnt_clr (cnt_clr),
    .count   (count),
    .ovf     (ovf),
    .an      (an),
    .seg     (seg)
  );

  typedef struct {
    int val;
    bit ovf;
    int at_edge;
  } exp_t;

  exp_t q[$];

  int vectors    = 0;
  int miscompares = 0;
  int edges      = 0;
  int k          = 0;
  int model_cnt  = 0;
  bit model_ovf  = 0;
  int disp_val   = 0;
  logic [15:0] prev_count = 16'h0000;
  logic        prev_ovf   = 1'b0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_of(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int pow10(input int s);
    int r = 1;
    for (int i = 0; i < s; i++) r = r * 10;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Edge counter and refresh position (clk edges since the last reset release)
  always @(posedge clk) begin
    edges++;
    if (!clr_n) k = 0;
    else k = k + 1;
  end

  // Monitor: pop expectations whenever the count/ovf outputs change, and check the display every cycle
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].at_edge < edges) begin
      vectors++;
      miscompares++;
      $display("FAIL missed_update: no change seen by edge %0d, want count %0d", q[0].at_edge, q[0].val);
      disp_val = q[0].val;
      void'(q.pop_front());
    end
    if (count !== prev_count || ovf !== prev_ovf) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_update: count %0h ovf %0b with nothing expected", count, ovf);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("count", 32'(count), 32'(bcd_of(e.val)));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("update_edge", edges, e.at_edge);
        disp_val = e.val;
      end
      prev_count = count;
      prev_ovf   = ovf;
    end
    if (clr_n === 1'b1) begin
      int s;
      int d;
      logic [3:0] want_an;
      logic [6:0] want_seg;
      s = (k / RD) % 4;
      d = (disp_val / pow10(s)) % 10;
      want_an  = ~(4'b0001 << s);
      want_seg = seg_tab[d];
`ifdef Z_CNT_BLANK_EN
      if (s > 0 && disp_val < pow10(s)) begin
        want_an  = 4'b1111;
        want_seg = 7'b1111111;
      end
      check("an", 32'(an), 32'(want_an));
      if (want_an != 4'b1111) check("seg", 32'(seg), 32'(want_seg));
`else
      check("an", 32'(an), 32'(want_an));
      check("seg", 32'(seg), 32'(want_seg));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic raise_z();
    exp_t e;
    z = 1'b1;
    model_cnt = model_cnt + 1;
    if (model_cnt == 10000) begin
      model_cnt = 0;
      model_ovf = 1'b1;
    end
    e.val = model_cnt;
    e.ovf = model_ovf;
    e.at_edge = edges + 3;
    q.push_back(e);
  endtask

  task automatic pulses(input int n, input bit fast);
    for (int i = 0; i < n; i++) begin
      raise_z();
      step(fast ? 1 : $urandom_range(1, 3));
      z = 1'b0;
      step(fast ? 1 : $urandom_range(1, 3));
    end
  endtask

  task automatic do_clear();
    exp_t e;
    cnt_clr = 1'b1;
    if (model_cnt != 0 || model_ovf) begin
      e.val = 0;
      e.ovf = 1'b0;
      e.at_edge = edges + 1;
      q.push_back(e);
    end
    model_cnt = 0;
    model_ovf = 1'b0;
    step(1);
    cnt_clr = 1'b0;
  endtask

  initial begin
    exp_t e;
    clr_n = 1'b0;
    z = 1'b0;
    cnt_clr = 1'b0;
    step(2);
    check("reset_count", 32'(count), 32'h0000);
    check("reset_ovf", 32'(ovf), 32'h0);
    check("reset_an", 32'(an), 32'hE);
    check("reset_seg", 32'(seg), 32'h40);
    clr_n = 1'b1;
    step(3);

    // single long pulse: visible exactly on the 3rd edge, counted once
    raise_z();
    step(2);
    check("pre_third_edge", 32'(count), 32'h0000);
    step(1);
    check("third_edge", 32'(count), 32'h0001);
    step(2);
    check("held_high", 32'(count), 32'h0001);
    z = 1'b0;
    step(4);

    // decade carries
    do_clear();
    pulses(10, 1'b0);
    step(4);
    check("ten_pulses", 32'(count), 32'h0010);
    pulses(90, 1'b0);
    step(4);
    check("hundred_pulses", 32'(count), 32'h0100);

    // clear collides with an increment: clear wins
    do_clear();
    pulses(42, 1'b0);
    step(4);
    check("count_42", 32'(count), 32'h0042);
    raise_z();
    model_cnt = 0;
    q.delete(q.size() - 1);
    step(2);
    cnt_clr = 1'b1;
    e.val = 0;
    e.ovf = 1'b0;
    e.at_edge = edges + 1;
    q.push_back(e);
    step(1);
    cnt_clr = 1'b0;
    z = 1'b0;
    step(4);
    check("clear_wins", 32'(count), 32'h0000);

    // display scan with a single non-zero digit
    pulses(7, 1'b0);
    step(4);
    step(16);

    // asynchronous reset mid-refresh
    do_clear();
    pulses(123, 1'b0);
    step(6);
    check("count_123", 32'(count), 32'h0123);
    e.val = 0;
    e.ovf = 1'b0;
    e.at_edge = edges + 1;
    q.push_back(e);
    clr_n = 1'b0;
    #1;
    check("async_count", 32'(count), 32'h0000);
    check("async_an", 32'(an), 32'hE);
    check("async_seg", 32'(seg), 32'h40);
    model_cnt = 0;
    model_ovf = 1'b0;
    step(2);
    clr_n = 1'b1;
    step(3);

    // wrap 9999 -> 0000 with sticky overflow
    pulses(9999, 1'b1);
    step(4);
    check("preload_9999", 32'(count), 32'h9999);
    check("preload_ovf", 32'(ovf), 32'h0);
    pulses(1, 1'b0);
    step(4);
    check("wrap_count", 32'(count), 32'h0000);
    check("wrap_ovf", 32'(ovf), 32'h1);
    step(8);
    check("ovf_sticky", 32'(ovf), 32'h1);
    do_clear();
    step(2);
    check("ovf_cleared", 32'(ovf), 32'h0);

    step(4);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
